param_shift_reg: RTL and testbench

- Parametrised universal shift register built from a WIDTH-bit register bank.
- Modes: hold, shift right, shift left, parallel load.
- Adds clock enable, synchronous reset, both serial outputs, and a shift counter with a "done" flag for serialiser use.
- Serves as the common PIPO/PISO/SIPO/SISO element for the datapath and serial-link blocks.

---
 rtl/param_shift_reg.sv | 98 +++++++++
 tb/tb_param_shift_reg.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/param_shift_reg.sv
// rtl/param_shift_reg.sv - universal shift register (hold/right/left/load) with shift counter and done flag
// Optional rotate input enabled by PARAM_SHIFT_REG_ROTATE_EN.
module param_shift_reg #(
    parameter int                WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b0}},
    localparam int               CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
`ifdef PARAM_SHIFT_REG_ROTATE_EN
    input  logic             rot,
`endif
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] pout,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             done
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_step;
    logic             in_r, in_l;

    // Rotation recirculates the outgoing bit instead of taking the serial input.
`ifdef PARAM_SHIFT_REG_ROTATE_EN
    assign in_r = rot ? q_q[0]       : sin_r;
    assign in_l = rot ? q_q[WIDTH-1] : sin_l;
`else
    assign in_r = sin_r;
    assign in_l = sin_l;
`endif

    assign cnt_step = (cnt_q < CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;

    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        if (en) begin
            case (mode)
                MODE_HOLD: begin
                    q_d = q_q;
                end
                MODE_RIGHT: begin
                    q_d    = {in_r, q_q[WIDTH-1:1]};
                    cnt_d  = cnt_step;
                    done_d = (cnt_step == CNT_MAX);
                end
                MODE_LEFT: begin
                    q_d    = {q_q[WIDTH-2:0], in_l};
                    cnt_d  = cnt_step;
                    done_d = (cnt_step == CNT_MAX);
                end
                MODE_LOAD: begin
                    q_d    = pin;
                    cnt_d  = '0;
                    done_d = 1'b0;
                end
                default: begin
                    q_d = q_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= RESET_VAL;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign pout      = q_q;
    assign sout_r    = q_q[0];
    assign sout_l    = q_q[WIDTH-1];
    assign shift_cnt = cnt_q;
    assign done      = done_q;

endmodule

// File: tb/tb_param_shift_reg.sv
// tb/tb_param_shift_reg.sv - table-driven scoreboard bench for param_shift_reg
// Rotate checks compiled in when PARAM_SHIFT_REG_ROTATE_EN is defined.
module tb_param_shift_reg;

    localparam int W = 8;

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic       sin_r;
        logic       sin_l;
        logic       rot;
        logic [7:0] pin;
        logic [7:0] exp_pout;
        logic [3:0] exp_cnt;
        logic       exp_done;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, en, sin_r, sin_l, rot;
    logic [1:0] mode;
    logic [7:0] pin, pout;
    logic       sout_r, sout_l, done;
    logic [3:0] shift_cnt;

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];

    always #5 clk = ~clk;

    param_shift_reg #(.WIDTH(W), .RESET_VAL(8'hA5)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .sin_r    (sin_r),
        .sin_l    (sin_l),
`ifdef PARAM_SHIFT_REG_ROTATE_EN
        .rot      (rot),
`endif
        .pin      (pin),
        .pout     (pout),
        .sout_r   (sout_r),
        .sout_l   (sout_l),
        .shift_cnt(shift_cnt),
        .done     (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic e, input logic [1:0] m,
                                input logic sr, input logic sl, input logic ro,
                                input logic [7:0] p, input logic [7:0] ep,
                                input logic [3:0] ec, input logic ed);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.sin_r = sr; v.sin_l = sl; v.rot = ro;
        v.pin = p; v.exp_pout = ep; v.exp_cnt = ec; v.exp_done = ed;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        rst = v.rst; en = v.en; mode = v.mode; sin_r = v.sin_r;
        sin_l = v.sin_l; rot = v.rot; pin = v.pin;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".pout"},   32'(pout),      32'(e.exp_pout));
            chk({tag, ".cnt"},    32'(shift_cnt), 32'(e.exp_cnt));
            chk({tag, ".done"},   32'(done),      32'(e.exp_done));
            chk({tag, ".sout_r"}, 32'(sout_r),    32'(e.exp_pout[0]));
            chk({tag, ".sout_l"}, 32'(sout_l),    32'(e.exp_pout[7]));
        end
    endtask

    initial begin
        vec_t       tbl[$];
        logic [7:0] exp_q;
        logic [7:0] src;
        logic [7:0] stream;

        rst = 1'b0; en = 1'b0; mode = 2'b00; sin_r = 1'b0; sin_l = 1'b0;
        rot = 1'b0; pin = 8'h00;
        @(posedge clk);
        #1;

        // reset beats a load; load/hold; en=0 blocks a load
        tbl.push_back(mk(1, 1, 2'b11, 0, 0, 0, 8'hFF, 8'hA5, 0, 0));
        tbl.push_back(mk(0, 1, 2'b11, 0, 0, 0, 8'h3C, 8'h3C, 0, 0));
        tbl.push_back(mk(0, 1, 2'b00, 1, 1, 0, 8'hFF, 8'h3C, 0, 0));
        tbl.push_back(mk(0, 1, 2'b00, 1, 1, 0, 8'hFF, 8'h3C, 0, 0));
        tbl.push_back(mk(0, 1, 2'b00, 1, 1, 0, 8'hFF, 8'h3C, 0, 0));
        tbl.push_back(mk(0, 0, 2'b11, 0, 0, 0, 8'h00, 8'h3C, 0, 0));
        tbl.push_back(mk(0, 0, 2'b01, 1, 1, 0, 8'h00, 8'h3C, 0, 0));
        tbl.push_back(mk(0, 1, 2'b01, 1, 0, 0, 8'h00, 8'h9E, 1, 0));
        tbl.push_back(mk(0, 1, 2'b10, 0, 1, 0, 8'h00, 8'h3D, 2, 0));
        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("tbl%0d", i));

        // PISO right: sout_r observed before each edge, saturation on 9th shift
        apply(mk(0, 1, 2'b11, 0, 0, 0, 8'hB1, 8'hB1, 0, 0), "piso_load");
        src = 8'hB1;
        exp_q = 8'hB1;
        for (int k = 1; k <= 9; k++) begin
            if (k <= 8) chk($sformatf("piso_sout%0d", k), 32'(sout_r), 32'(src[k-1]));
            exp_q = exp_q >> 1;
            apply(mk(0, 1, 2'b01, 0, 0, 0, 8'h00, exp_q, (k >= 8) ? 4'd8 : 4'(k), k >= 8),
                  $sformatf("piso%0d", k));
        end
        apply(mk(0, 1, 2'b00, 0, 0, 0, 8'h00, 8'h00, 8, 1), "piso_hold");

        // SIPO left
        apply(mk(0, 1, 2'b11, 0, 0, 0, 8'h00, 8'h00, 0, 0), "sipo_load");
        stream = 8'b1101_0010;
        exp_q = 8'h00;
        for (int k = 0; k < 8; k++) begin
            exp_q = {exp_q[6:0], stream[7-k]};
            apply(mk(0, 1, 2'b10, 0, stream[7-k], 0, 8'h00, exp_q, 4'(k + 1), k == 7),
                  $sformatf("sipo%0d", k));
        end
        chk("sipo_final", 32'(pout), 32'hD2);
        apply(mk(0, 1, 2'b11, 0, 0, 0, 8'h00, 8'h00, 0, 0), "sipo_reload");

        // mixed directions keep counting
        for (int k = 0; k < 8; k++)
            apply(mk(0, 1, (k % 2 == 0) ? 2'b01 : 2'b10, 0, 0, 0, 8'h00, 8'h00,
                     4'(k + 1), k == 7), $sformatf("mix%0d", k));

        // reset mid-serialise
        apply(mk(0, 1, 2'b11, 0, 0, 0, 8'hFF, 8'hFF, 0, 0), "mid_load");
        apply(mk(0, 1, 2'b01, 0, 0, 0, 8'h00, 8'h7F, 1, 0), "mid1");
        apply(mk(0, 1, 2'b01, 0, 0, 0, 8'h00, 8'h3F, 2, 0), "mid2");
        apply(mk(0, 1, 2'b01, 0, 0, 0, 8'h00, 8'h1F, 3, 0), "mid3");
        apply(mk(1, 1, 2'b01, 1, 1, 0, 8'h00, 8'hA5, 0, 0), "mid_rst");

`ifdef PARAM_SHIFT_REG_ROTATE_EN
        apply(mk(0, 1, 2'b11, 0, 0, 1, 8'h81, 8'h81, 0, 0), "rot_load");
        apply(mk(0, 1, 2'b10, 0, 0, 1, 8'h00, 8'h03, 1, 0), "rot_left");
        apply(mk(0, 1, 2'b01, 0, 0, 1, 8'h00, 8'h81, 2, 0), "rot_right");
        apply(mk(0, 1, 2'b01, 0, 0, 0, 8'h00, 8'h40, 3, 0), "rot_off");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
